alarm_bank: RTL and testbench
=============================

ALARM_BANK -- requirements
Module: alarm_bank

Interface
REQ-001 SHALL have parameter N_ALARMS, default 4: number of independent alarm channels (1..16).
REQ-002 SHALL have parameter RING_SECS, default 60: ticks a channel rings before auto-stop (1..255).
REQ-003 SHALL have parameter SNOOZE_SECS, default 300: ticks a snoozed channel waits before re-ringing (1..4095).
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 tick  in  1  one-cycle 1 Hz strobe, asserted in the cycle the time inputs take a new value.
REQ-007 sec_in / min_in / hour_in  in  6/6/5  current time of day.
REQ-008 sel_alarm  in  $clog2(N_ALARMS) (min 1)  channel targeted by edit/arm commands.
REQ-009 select  in  2  field to edit: SELECT_SEC, SELECT_MIN, SELECT_HOUR; other codes edit nothing.
REQ-010 increment / arm_toggle / snooze / dismiss  in  1 each  one-cycle command pulses.
REQ-011 sec_out / min_out / hour_out  out  6/6/5  stored alarm time of sel_alarm channel (combinational read).
REQ-012 armed  out  N_ALARMS  per-channel armed flags.
REQ-013 ringing  out  N_ALARMS  per-channel ringing flags, registered.
REQ-014 out  out  1  OR of ringing.

Function
REQ-015 Each channel SHALL hold sec/min/hour setting, armed flag, state {IDLE, RINGING, SNOOZED}, and a 12-bit countdown.
REQ-016 increment SHALL add 1 to the selected field of sel_alarm channel with wrap 59->0 (sec, min) and 23->0 (hour); no carry into other fields.
REQ-017 arm_toggle SHALL invert armed of sel_alarm channel; disarming a RINGING or SNOOZED channel SHALL force it to IDLE in the same edge.
REQ-018 sel_alarm >= N_ALARMS SHALL make increment and arm_toggle no-ops; read outputs SHALL return 0.
REQ-019 Match: in a cycle with tick=1, an armed IDLE channel whose setting equals (hour_in,min_in,sec_in) SHALL enter RINGING at that edge, countdown=RING_SECS; match without tick SHALL be ignored.
REQ-020 RINGING: each tick decrements countdown; when a tick arrives with countdown=1 the channel SHALL return to IDLE (rings exactly RING_SECS ticks).
REQ-021 snooze SHALL move every RINGING channel to SNOOZED with countdown=SNOOZE_SECS; no effect on IDLE/SNOOZED channels.
REQ-022 SNOOZED: each tick decrements countdown; tick with countdown=1 SHALL re-enter RINGING with countdown=RING_SECS.
REQ-023 dismiss SHALL move every RINGING and SNOOZED channel to IDLE; armed flags unchanged.
REQ-024 Priority per channel per edge: reset > disarm (REQ-017) > dismiss > snooze > tick-driven transitions.
REQ-025 A channel in RINGING or SNOOZED SHALL ignore new matches; a match coinciding with dismiss SHALL not ring.
REQ-026 Editing a channel's time while RINGING/SNOOZED SHALL not change its state or countdown.
REQ-027 ringing[i] SHALL be 1 exactly while channel i is RINGING (state-derived, same edge as transition).
REQ-028 Multiple channels MAY ring simultaneously; out covers all.

Reset
REQ-029 reset=0 at a clock edge SHALL clear all settings to 00:00:00, armed to 0, states to IDLE, countdowns to 0; ringing and out read 0 from the next edge.
REQ-030 Reset mid-ring or mid-snooze SHALL abort with no residual ringing; commands during reset SHALL be ignored.

Structure
REQ-031 SELECT_SEC/MIN/HOUR codes and the state encodings ALM_IDLE/ALM_RINGING/ALM_SNOOZED SHALL live in the shared constants file.
REQ-032 One sub-module alarm_channel (setting, armed, FSM, countdown) SHALL be instantiated N_ALARMS times by generate; alarm_bank decodes sel_alarm, muxes read outputs, ORs out.

Verification
REQ-033 Reset, set ch0 to 00:00:03 (3 increments, select=SEC), arm; ticks at 00:00:00..03 -> ringing=0001 on the 00:00:03 tick edge, out=1.
REQ-034 RING_SECS=3: after match, 3 further ticks -> ringing[0] falls on the 3rd tick; no ring on non-tick cycles with matching time.
REQ-035 Ringing ch0, snooze, SNOOZE_SECS=5 -> ringing=0 next edge; re-rings on 5th tick; then dismiss -> IDLE, armed[0] stays 1.
REQ-036 Hour field 23, increment -> hour_out=0; sec 59 increment -> 0, min unchanged.
REQ-037 Ch1 and ch2 set to same time, both armed -> both ringing bits set same edge; arm_toggle ch1 -> only ch2 rings.
REQ-038 reset=0 while ch0 SNOOZED -> all outputs 0 next edge; remains silent after countdown would have expired.

Source files
------------

// File: rtl/alarm_bank_pkg.sv
// Shared constants for the alarm bank: edit-field codes, channel states and
// the wrap-around helpers used when editing a stored alarm time.
package alarm_bank_pkg;

  localparam logic [1:0] SELECT_SEC  = 2'd0;
  localparam logic [1:0] SELECT_MIN  = 2'd1;
  localparam logic [1:0] SELECT_HOUR = 2'd2;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    ALM_IDLE    = 2'd0,
    ALM_RINGING = 2'd1,
    ALM_SNOOZED = 2'd2
  } alm_state_t;

  function automatic logic [5:0] incSixty(input logic [5:0] value);
    return (value >= 6'd59) ? 6'd0 : value + 6'd1;
  endfunction

  function automatic logic [4:0] incHour(input logic [4:0] value);
    return (value >= 5'd23) ? 5'd0 : value + 5'd1;
  endfunction

endpackage

// File: rtl/alarm_bank_channel.sv
// One alarm channel: stored time, armed flag, ring/snooze state machine and
// its shared ring/snooze countdown.
module alarm_channel
  import alarm_bank_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  input  logic [4:0] hour_in,
  input  logic       sel,
  input  logic [1:0] select,
  input  logic       increment,
  input  logic       arm_toggle,
  input  logic       snooze,
  input  logic       dismiss,
  output logic [5:0] sec_out,
  output logic [5:0] min_out,
  output logic [4:0] hour_out,
  output logic       armed,
  output logic       ringing
);

  localparam logic [CNT_W-1:0] RING_CNT   = CNT_W'(RING_SECS);
  localparam logic [CNT_W-1:0] SNOOZE_CNT = CNT_W'(SNOOZE_SECS);

  logic [5:0]       r_sec;
  logic [5:0]       r_min;
  logic [4:0]       r_hour;
  logic             r_armed;
  alm_state_t       r_state;
  logic [CNT_W-1:0] r_count;

  alm_state_t       w_stateNext;
  logic [CNT_W-1:0] w_countNext;
  logic             w_disarm;
  logic             w_match;

  // Editing touches only the setting and armed flag, never the ring state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sec   <= '0;
      r_min   <= '0;
      r_hour  <= '0;
      r_armed <= 1'b0;
    end else begin
      if (sel && increment) begin
        case (select)
          SELECT_SEC:  r_sec  <= incSixty(r_sec);
          SELECT_MIN:  r_min  <= incSixty(r_min);
          SELECT_HOUR: r_hour <= incHour(r_hour);
          default: ;
        endcase
      end
      if (sel && arm_toggle) r_armed <= ~r_armed;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ALM_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
    end
  end

  // Disarm beats dismiss beats snooze beats anything the tick would do.
  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_disarm    = sel && arm_toggle && r_armed;
    w_match     = tick && r_armed &&
                  (r_sec == sec_in) && (r_min == min_in) && (r_hour == hour_in);
    if (w_disarm || dismiss) begin
      w_stateNext = ALM_IDLE;
      w_countNext = '0;
    end else if (snooze && (r_state == ALM_RINGING)) begin
      w_stateNext = ALM_SNOOZED;
      w_countNext = SNOOZE_CNT;
    end else if (tick) begin
      case (r_state)
        ALM_IDLE: begin
          if (w_match) begin
            w_stateNext = ALM_RINGING;
            w_countNext = RING_CNT;
          end
        end
        ALM_RINGING: begin
          if (r_count <= 12'd1) begin
            w_stateNext = ALM_IDLE;
            w_countNext = '0;
          end else begin
            w_countNext = r_count - 12'd1;
          end
        end
        ALM_SNOOZED: begin
          if (r_count <= 12'd1) begin
            w_stateNext = ALM_RINGING;
            w_countNext = RING_CNT;
          end else begin
            w_countNext = r_count - 12'd1;
          end
        end
        default: begin
          w_stateNext = ALM_IDLE;
          w_countNext = '0;
        end
      endcase
    end
  end

  assign sec_out  = r_sec;
  assign min_out  = r_min;
  assign hour_out = r_hour;
  assign armed    = r_armed;
  assign ringing  = (r_state == ALM_RINGING);

endmodule

// File: rtl/alarm_bank.sv
// Bank of independent alarm channels: decodes the edit target, multiplexes
// the selected channel's stored time and merges all ringing flags.
module alarm_bank
  import alarm_bank_pkg::*;
#(
  parameter int N_ALARMS    = 4,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  localparam int SEL_W      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [5:0]          sec_in,
  input  logic [5:0]          min_in,
  input  logic [4:0]          hour_in,
  input  logic [SEL_W-1:0]    sel_alarm,
  input  logic [1:0]          select,
  input  logic                increment,
  input  logic                arm_toggle,
  input  logic                snooze,
  input  logic                dismiss,
  output logic [5:0]          sec_out,
  output logic [5:0]          min_out,
  output logic [4:0]          hour_out,
  output logic [N_ALARMS-1:0] armed,
  output logic [N_ALARMS-1:0] ringing,
  output logic                out
);

  logic [N_ALARMS-1:0] w_sel;
  logic [5:0]          w_secArr  [N_ALARMS];
  logic [5:0]          w_minArr  [N_ALARMS];
  logic [4:0]          w_hourArr [N_ALARMS];

  // An out-of-range sel_alarm matches no channel, so edits are dropped.
  for (genvar g = 0; g < N_ALARMS; g++) begin : g_chan
    assign w_sel[g] = (sel_alarm == SEL_W'(g));

    alarm_channel #(
      .RING_SECS  (RING_SECS),
      .SNOOZE_SECS(SNOOZE_SECS)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .sec_in    (sec_in),
      .min_in    (min_in),
      .hour_in   (hour_in),
      .sel       (w_sel[g]),
      .select    (select),
      .increment (increment),
      .arm_toggle(arm_toggle),
      .snooze    (snooze),
      .dismiss   (dismiss),
      .sec_out   (w_secArr[g]),
      .min_out   (w_minArr[g]),
      .hour_out  (w_hourArr[g]),
      .armed     (armed[g]),
      .ringing   (ringing[g])
    );
  end

  always_comb begin
    sec_out  = '0;
    min_out  = '0;
    hour_out = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      if (w_sel[i]) begin
        sec_out  = w_secArr[i];
        min_out  = w_minArr[i];
        hour_out = w_hourArr[i];
      end
    end
  end

  assign out = |ringing;

endmodule

// File: tb/tb_alarm_bank.sv
// Self-checking bench for alarm_bank: vector table applied through an
// expected-value queue, compared one cycle-sample after each clock edge.
module tb_alarm_bank;
  import alarm_bank_pkg::*;

  localparam int NA = 3;
  localparam logic [1:0] SEL_NONE = 2'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic [5:0]    sec_in, min_in;
  logic [4:0]    hour_in;
  logic [1:0]    sel_alarm;
  logic [1:0]    select;
  logic          increment, arm_toggle, snooze, dismiss;
  logic [5:0]    sec_out, min_out;
  logic [4:0]    hour_out;
  logic [NA-1:0] armed, ringing;
  logic          out;

  alarm_bank #(.N_ALARMS(NA), .RING_SECS(3), .SNOOZE_SECS(5)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .sec_in(sec_in), .min_in(min_in), .hour_in(hour_in),
    .sel_alarm(sel_alarm), .select(select),
    .increment(increment), .arm_toggle(arm_toggle),
    .snooze(snooze), .dismiss(dismiss),
    .sec_out(sec_out), .min_out(min_out), .hour_out(hour_out),
    .armed(armed), .ringing(ringing), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rstN;
    logic          tk;
    logic [4:0]    h;
    logic [5:0]    m;
    logic [5:0]    s;
    logic [1:0]    sa;
    logic [1:0]    sl;
    logic          inc, arm, snz, dis;
    logic [NA-1:0] expRing;
    logic [NA-1:0] expArmed;
    logic [4:0]    eh;
    logic [5:0]    em;
    logic [5:0]    es;
  } vec_t;

  vec_t vecs[$];
  vec_t sbq[$];
  int   nCompared   = 0;
  int   nMismatched = 0;

  task automatic addVec(input logic rstN, input logic tk,
                        input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                        input logic [1:0] sa, input logic [1:0] sl,
                        input logic inc, input logic arm, input logic snz, input logic dis,
                        input logic [NA-1:0] expRing, input logic [NA-1:0] expArmed,
                        input logic [4:0] eh, input logic [5:0] em, input logic [5:0] es);
    vec_t v;
    v.rstN = rstN; v.tk = tk; v.h = h; v.m = m; v.s = s;
    v.sa = sa; v.sl = sl; v.inc = inc; v.arm = arm; v.snz = snz; v.dis = dis;
    v.expRing = expRing; v.expArmed = expArmed; v.eh = eh; v.em = em; v.es = es;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset = v.rstN; tick = v.tk;
    hour_in = v.h; min_in = v.m; sec_in = v.s;
    sel_alarm = v.sa; select = v.sl;
    increment = v.inc; arm_toggle = v.arm; snooze = v.snz; dismiss = v.dis;
    sbq.push_back(v);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    logic [16:0] gotT, expT;
    if (sbq.size() == 0) begin
      nCompared++; nMismatched++;
      $display("[TB] FAIL vec%0d.queue: no expected entry", idx);
      return;
    end
    e = sbq.pop_front();
    gotT = {hour_out, min_out, sec_out};
    expT = {e.eh, e.em, e.es};
    nCompared++;
    if (ringing !== e.expRing) begin
      nMismatched++;
      $display("[TB] FAIL vec%0d.ringing: got %b want %b", idx, ringing, e.expRing);
    end
    nCompared++;
    if (out !== (|e.expRing)) begin
      nMismatched++;
      $display("[TB] FAIL vec%0d.out: got %b want %b", idx, out, |e.expRing);
    end
    nCompared++;
    if (armed !== e.expArmed) begin
      nMismatched++;
      $display("[TB] FAIL vec%0d.armed: got %b want %b", idx, armed, e.expArmed);
    end
    nCompared++;
    if (gotT !== expT) begin
      nMismatched++;
      $display("[TB] FAIL vec%0d.time: got %0d:%0d:%0d want %0d:%0d:%0d",
               idx, hour_out, min_out, sec_out, e.eh, e.em, e.es);
    end
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; hour_in = '0; min_in = '0; sec_in = '0;
    sel_alarm = '0; select = SEL_NONE;
    increment = 1'b0; arm_toggle = 1'b0; snooze = 1'b0; dismiss = 1'b0;

    // Reset, with commands during reset that must be ignored
    addVec(0,0, 0,0,0, 0,SEL_NONE, 0,0,0,0, 3'b000,3'b000, 0,0,0);
    addVec(0,1, 0,0,3, 0,SELECT_SEC, 1,1,0,0, 3'b000,3'b000, 0,0,0);
    addVec(1,0, 0,0,0, 0,SEL_NONE, 0,0,0,0, 3'b000,3'b000, 0,0,0);
    // Set ch0 to 00:00:03 and arm
    for (int k = 1; k <= 3; k++)
      addVec(1,0, 0,0,0, 0,SELECT_SEC, 1,0,0,0, 3'b000,3'b000, 0,0,6'(k));
    addVec(1,0, 0,0,0, 0,SEL_NONE, 0,1,0,0, 3'b000,3'b001, 0,0,3);
    for (int k = 0; k <= 2; k++)
      addVec(1,1, 0,0,6'(k), 0,SEL_NONE, 0,0,0,0, 3'b000,3'b001, 0,0,3);
    // Matching time without tick is ignored, then the tick rings
    addVec(1,0, 0,0,3, 0,SEL_NONE, 0,0,0,0, 3'b000,3'b001, 0,0,3);
    addVec(1,1, 0,0,3, 0,SEL_NONE, 0,0,0,0, 3'b001,3'b001, 0,0,3);
    addVec(1,0, 0,0,3, 0,SEL_NONE, 0,0,0,0, 3'b001,3'b001, 0,0,3);
    addVec(1,1, 0,0,4, 0,SEL_NONE, 0,0,0,0, 3'b001,3'b001, 0,0,3);
    addVec(1,1, 0,0,5, 0,SEL_NONE, 0,0,0,0, 3'b001,3'b001, 0,0,3);
    addVec(1,1, 0,0,6, 0,SEL_NONE, 0,0,0,0, 3'b000,3'b001, 0,0,3);
    // Ring, snooze for 5 ticks, re-ring, dismiss
    addVec(1,1, 0,0,3, 0,SEL_NONE, 0,0,0,0, 3'b001,3'b001, 0,0,3);
    addVec(1,0, 0,0,3, 0,SEL_NONE, 0,0,1,0, 3'b000,3'b001, 0,0,3);
    for (int k = 0; k < 4; k++)
      addVec(1,1, 0,0,6'(10+k), 0,SEL_NONE, 0,0,0,0, 3'b000,3'b001, 0,0,3);
    addVec(1,1, 0,0,14, 0,SEL_NONE, 0,0,0,0, 3'b001,3'b001, 0,0,3);
    addVec(1,0, 0,0,14, 0,SEL_NONE, 0,0,0,1, 3'b000,3'b001, 0,0,3);
    // Match coinciding with dismiss must not ring
    addVec(1,1, 0,0,3, 0,SEL_NONE, 0,0,0,1, 3'b000,3'b001, 0,0,3);
    // Editing while ringing keeps state and countdown
    addVec(1,1, 0,0,3, 0,SEL_NONE, 0,0,0,0, 3'b001,3'b001, 0,0,3);
    addVec(1,0, 0,0,3, 0,SELECT_SEC, 1,0,0,0, 3'b001,3'b001, 0,0,4);
    addVec(1,1, 0,0,20, 0,SEL_NONE, 0,0,0,0, 3'b001,3'b001, 0,0,4);
    addVec(1,1, 0,0,21, 0,SEL_NONE, 0,0,0,0, 3'b001,3'b001, 0,0,4);
    addVec(1,1, 0,0,22, 0,SEL_NONE, 0,0,0,0, 3'b000,3'b001, 0,0,4);
    // Out-of-range channel: edits dropped, read returns zero
    addVec(1,0, 0,0,0, 3,SELECT_SEC, 1,0,0,0, 3'b000,3'b001, 0,0,0);
    addVec(1,0, 0,0,0, 3,SEL_NONE, 0,1,0,0, 3'b000,3'b001, 0,0,0);
    addVec(1,0, 0,0,0, 0,SEL_NONE, 0,0,0,0, 3'b000,3'b001, 0,0,4);
    // Field wrap on ch2 with no carry between fields
    for (int k = 1; k <= 24; k++)
      addVec(1,0, 0,0,0, 2,SELECT_HOUR, 1,0,0,0, 3'b000,3'b001, 5'(k % 24),0,0);
    addVec(1,0, 0,0,0, 2,SELECT_MIN, 1,0,0,0, 3'b000,3'b001, 0,1,0);
    addVec(1,0, 0,0,0, 2,SEL_NONE, 1,0,0,0, 3'b000,3'b001, 0,1,0);
    for (int k = 1; k <= 60; k++)
      addVec(1,0, 0,0,0, 2,SELECT_SEC, 1,0,0,0, 3'b000,3'b001, 0,1,6'(k % 60));
    for (int k = 2; k <= 60; k++)
      addVec(1,0, 0,0,0, 2,SELECT_MIN, 1,0,0,0, 3'b000,3'b001, 0,6'(k % 60),0);
    // Two channels ring together; disarming one silences only it
    addVec(1,0, 0,0,0, 1,SEL_NONE, 0,1,0,0, 3'b000,3'b011, 0,0,0);
    addVec(1,0, 0,0,0, 2,SEL_NONE, 0,1,0,0, 3'b000,3'b111, 0,0,0);
    addVec(1,1, 0,0,0, 2,SEL_NONE, 0,0,0,0, 3'b110,3'b111, 0,0,0);
    addVec(1,0, 0,0,1, 1,SEL_NONE, 0,1,0,0, 3'b100,3'b101, 0,0,0);
    addVec(1,0, 0,0,1, 0,SEL_NONE, 0,0,0,1, 3'b000,3'b101, 0,0,4);
    // Reset while ch0 is snoozed leaves everything silent afterwards
    addVec(1,1, 0,0,4, 0,SEL_NONE, 0,0,0,0, 3'b001,3'b101, 0,0,4);
    addVec(1,0, 0,0,4, 0,SEL_NONE, 0,0,1,0, 3'b000,3'b101, 0,0,4);
    addVec(1,1, 0,0,5, 0,SEL_NONE, 0,0,0,0, 3'b000,3'b101, 0,0,4);
    addVec(0,1, 0,0,6, 0,SELECT_SEC, 1,0,0,0, 3'b000,3'b000, 0,0,0);
    for (int k = 0; k < 6; k++)
      addVec(1,1, 0,0,6'(7+k), 0,SEL_NONE, 0,0,0,0, 3'b000,3'b000, 0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
